window_3x3_gen: RTL and testbench
=================================

WINDOW_3X3_GEN -- requirements
Module: window_3x3_gen

Interface
REQ-001 Parameter IMG_W, default 64, pixels per line (legal range 3..1024).
REQ-002 Parameter IMG_H, default 64, lines per frame (legal range 3..1024).
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 sof  input  1  start-of-frame; qualifies the same-cycle pixel as (row 0, col 0).
REQ-006 pix_valid  input  1  pixel strobe; high = pix_in is accepted this cycle.
REQ-007 pix_in  input  8  raster-order grayscale pixel.
REQ-008 a,b,c,d,e,f,g,h,i  output  8 each  3x3 window, registered.
  - a,b,c: top (oldest) row; d,e,f: middle row; g,h,i: bottom row.
  - Within each row, left to right.
REQ-009 win_valid  output  1  window outputs hold a complete, fully interior window.
REQ-010 win_en_n  output  1  active-low enable for the edge-detect stage; always equal to ~win_valid.

Function
REQ-011 The block SHALL keep two line buffers of IMG_W x 8 bits holding the previous two lines, plus a 3x3 shift register.
REQ-012 On an accepted pixel at (row r, col k), the block SHALL shift the window left one column and load column {line_buf1[k], line_buf0[k], pix_in} into c/f/i.
  - line_buf1 is two lines back; line_buf0 is one line back.
REQ-013 On the same edge, the block SHALL write line_buf0[k] into line_buf1[k] and pix_in into line_buf0[k].
REQ-014 The column counter SHALL increment per accepted pixel and wrap from IMG_W-1 to 0, incrementing the row counter on wrap.
REQ-015 The row counter SHALL wrap from IMG_H-1 to 0.
REQ-016 win_valid SHALL assert for exactly one cycle, the cycle after an accepted pixel with r>=2 and k>=2.
  - Latency is 1 cycle from pixel acceptance to window.
  - Centre e is then pixel (r-1, k-1).
REQ-017 When pix_valid is low, the block SHALL hold the window registers, counters and line buffers, and SHALL deassert win_valid in the following cycle.
REQ-018 sof with pix_valid high SHALL force that pixel to (0,0) regardless of the counter state; the counters continue from (0,1).
REQ-019 sof with pix_valid low SHALL clear both counters to 0 and SHALL NOT write any state.
REQ-020 After each line wrap, the window SHALL NOT emit a window spanning two lines; the first valid window of a line is at k=2.
REQ-021 Per frame, the block SHALL produce exactly (IMG_W-2)*(IMG_H-2) valid windows.
REQ-022 The block SHALL apply no back-pressure; every pixel presented with pix_valid high is accepted.

Reset
REQ-023 While rst_n is low, the block SHALL hold:
  - row and column counters at 0;
  - a..i at 0;
  - win_valid at 0 and win_en_n at 1.
REQ-024 Line buffer contents SHALL NOT be reset; REQ-016 guarantees stale data is never exposed.
REQ-025 Reset asserted mid-frame SHALL abort the frame; the next accepted pixel is treated as (0,0).

Configuration
REQ-026 With macro WIN_FRAME_DONE_EN defined, the block SHALL add output frame_done  output  1.
  - frame_done pulses high for one cycle, coincident with the win_valid of the window whose newest pixel is (IMG_H-1, IMG_W-1).
  - frame_done resets to 0.
REQ-027 With WIN_FRAME_DONE_EN undefined, the frame_done port and its logic SHALL be absent; all other behaviour is identical.

Verification
REQ-028 IMG_W=IMG_H=4, pixel value = 16*row+col streamed continuously -> exactly 4 win_valid pulses.
  - First pulse: a..i = 0,1,2,16,17,18,32,33,34.
  - Last pulse: e=0x22 (34), i=0x33 (51).
REQ-029 Same stream with pix_valid low for 3 cycles after pixel (2,2).
  - Window held.
  - win_valid low during the gap.
  - Next window after resumption: a..i = 1,2,3,17,18,19,33,34,35.
REQ-030 Line wrap: no win_valid at (r,0) or (r,1) for any r; win_en_n equals ~win_valid every cycle.
REQ-031 rst_n pulsed low mid-row 2, then sof plus a fresh frame.
  - Outputs 0 and win_valid 0 immediately, asynchronously.
  - The fresh frame yields the same 4 windows as REQ-028.
REQ-032 With WIN_FRAME_DONE_EN defined: frame_done high only with the window for pixel (3,3), once per frame across two back-to-back frames.

Source files
------------

// File: rtl/window_3x3_gen.sv
// rtl/window_3x3_gen.sv - 3x3 sliding window generator over a raster pixel stream (optional WIN_FRAME_DONE_EN adds frame_done)
module window_3x3_gen #(
    parameter int IMG_W = 64,
    parameter int IMG_H = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sof,
    input  logic       pix_valid,
    input  logic [7:0] pix_in,
    output logic [7:0] a,
    output logic [7:0] b,
    output logic [7:0] c,
    output logic [7:0] d,
    output logic [7:0] e,
    output logic [7:0] f,
    output logic [7:0] g,
    output logic [7:0] h,
    output logic [7:0] i,
    output logic       win_valid,
`ifdef WIN_FRAME_DONE_EN
    output logic       frame_done,
`endif
    output logic       win_en_n
);

    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

    logic [CW-1:0] col_q, col_cur, col_nxt;
    logic [RW-1:0] row_q, row_cur, row_nxt;

    logic [7:0] line_buf0 [IMG_W];
    logic [7:0] line_buf1 [IMG_W];
    logic [7:0] lb0_rd, lb1_rd;

    logic win_fire;

    // sof overrides the counters for the current pixel, so position is resolved combinationally
    always_comb begin
        col_cur = sof ? '0 : col_q;
        row_cur = sof ? '0 : row_q;
        col_nxt = col_cur;
        row_nxt = row_cur;
        if (pix_valid) begin
            if (col_cur == COL_LAST) begin
                col_nxt = '0;
                row_nxt = (row_cur == ROW_LAST) ? '0 : row_cur + RW'(1);
            end else begin
                col_nxt = col_cur + CW'(1);
            end
        end
    end

    assign lb0_rd   = line_buf0[col_cur];
    assign lb1_rd   = line_buf1[col_cur];
    assign win_fire = pix_valid && (row_cur >= RW'(2)) && (col_cur >= CW'(2));

    // line buffers carry no reset; stale contents never reach a valid window
    always_ff @(posedge clk) begin
        if (pix_valid) begin
            line_buf1[col_cur] <= lb0_rd;
            line_buf0[col_cur] <= pix_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q     <= '0;
            row_q     <= '0;
            a         <= '0;
            b         <= '0;
            c         <= '0;
            d         <= '0;
            e         <= '0;
            f         <= '0;
            g         <= '0;
            h         <= '0;
            i         <= '0;
            win_valid <= 1'b0;
        end else begin
            col_q     <= col_nxt;
            row_q     <= row_nxt;
            win_valid <= win_fire;
            if (pix_valid) begin
                a <= b;
                b <= c;
                c <= lb1_rd;
                d <= e;
                e <= f;
                f <= lb0_rd;
                g <= h;
                h <= i;
                i <= pix_in;
            end
        end
    end

`ifdef WIN_FRAME_DONE_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_done <= 1'b0;
        end else begin
            frame_done <= pix_valid && (row_cur == ROW_LAST) && (col_cur == COL_LAST);
        end
    end
`endif

    assign win_en_n = ~win_valid;

endmodule

// File: tb/tb_window_3x3_gen.sv
// tb/tb_window_3x3_gen.sv - self-checking bench for window_3x3_gen against an image-array model
module tb_window_3x3_gen;

    localparam int W = 4;
    localparam int H = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sof = 1'b0;
    logic       pix_valid = 1'b0;
    logic [7:0] pix_in = 8'd0;
    logic [7:0] a, b, c, d, e, f, g, h, i;
    logic       win_valid, win_en_n;
`ifdef WIN_FRAME_DONE_EN
    logic       frame_done;
`endif

    always #5 clk = ~clk;

    window_3x3_gen #(.IMG_W(W), .IMG_H(H)) dut (
        .clk(clk), .rst_n(rst_n), .sof(sof), .pix_valid(pix_valid), .pix_in(pix_in),
        .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g), .h(h), .i(i),
        .win_valid(win_valid),
`ifdef WIN_FRAME_DONE_EN
        .frame_done(frame_done),
`endif
        .win_en_n(win_en_n)
    );

    int tests = 0;
    int fails = 0;
    logic [7:0]  img [0:H-1][0:W-1];
    logic [71:0] exp_win;
    bit          known, exp_valid, exp_fd, checking;
    int          cur_r, cur_k, win_cnt, fd_cnt;

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [71:0] dut_win();
        return {a, b, c, d, e, f, g, h, i};
    endfunction

    always @(posedge clk) begin
        #2;
        if (checking) begin
            chk("win_valid", win_valid, exp_valid);
            chk("win_en_n", win_en_n, !exp_valid);
            if (known) chk("window", dut_win(), exp_win);
`ifdef WIN_FRAME_DONE_EN
            chk("frame_done", frame_done, exp_fd);
            if (frame_done) fd_cnt++;
`endif
            if (win_valid) win_cnt++;
        end
    end

    // Drive one cycle and record what the outputs must be after the next edge
    task automatic px(input bit s, input bit v, input logic [7:0] p);
        int r, k;
        @(negedge clk);
        sof = s;
        pix_valid = v;
        pix_in = p;
        if (v) begin
            if (s) begin
                cur_r = 0;
                cur_k = 0;
            end
            r = cur_r;
            k = cur_k;
            img[r][k] = p;
            exp_valid = (r >= 2 && k >= 2);
            exp_fd = (r == H - 1 && k == W - 1);
            if (exp_valid) begin
                exp_win = {img[r-2][k-2], img[r-2][k-1], img[r-2][k],
                           img[r-1][k-2], img[r-1][k-1], img[r-1][k],
                           img[r][k-2],   img[r][k-1],   img[r][k]};
                known = 1'b1;
            end else begin
                known = 1'b0;
            end
            cur_k++;
            if (cur_k == W) begin
                cur_k = 0;
                cur_r = (cur_r == H - 1) ? 0 : cur_r + 1;
            end
        end else begin
            exp_valid = 1'b0;
            exp_fd = 1'b0;
            if (s) begin
                cur_r = 0;
                cur_k = 0;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int j = 0; j < n; j++) px(1'b0, 1'b0, 8'd0);
    endtask

    task automatic model_reset();
        known = 1'b1;
        exp_win = '0;
        exp_valid = 1'b0;
        exp_fd = 1'b0;
        cur_r = 0;
        cur_k = 0;
    endtask

    localparam logic [71:0] FIRST_WIN  = 72'h00_01_02_10_11_12_20_21_22;
    localparam logic [71:0] RESUME_WIN = 72'h01_02_03_11_12_13_21_22_23;

    initial begin
        checking = 1'b0;
        win_cnt = 0;
        fd_cnt = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #3;
        chk("rst_window", dut_win(), '0);
        chk("rst_win_valid", win_valid, 1'b0);
        chk("rst_win_en_n", win_en_n, 1'b1);
        checking = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;

        // ramp frame, value = 16*row+col
        win_cnt = 0;
        for (int r = 0; r < H; r++)
            for (int k = 0; k < W; k++) begin
                px(r == 0 && k == 0, 1'b1, 8'(16 * r + k));
                if (r == 2 && k == 2) begin
                    @(posedge clk); #3;
                    chk("first_win", dut_win(), FIRST_WIN);
                end
                if (r == 3 && k == 3) begin
                    @(posedge clk); #3;
                    chk("last_e", e, 8'h22);
                    chk("last_i", i, 8'h33);
                end
            end
        idle(2);
        chk("ramp_count", win_cnt, 4);

        // 3-cycle gap after pixel (2,2)
        win_cnt = 0;
        for (int r = 0; r < H; r++)
            for (int k = 0; k < W; k++) begin
                px(r == 0 && k == 0, 1'b1, 8'(16 * r + k));
                if (r == 2 && k == 2) begin
                    idle(3);
                    @(posedge clk); #3;
                    chk("gap_hold", dut_win(), FIRST_WIN);
                end
                if (r == 2 && k == 3) begin
                    @(posedge clk); #3;
                    chk("resume_win", dut_win(), RESUME_WIN);
                end
            end
        idle(2);
        chk("gap_count", win_cnt, 4);

        // asynchronous reset mid-row 2, then a fresh frame
        for (int n = 0; n < 2 * W + 2; n++) px(n == 0, 1'b1, 8'(16 * (n / W) + n % W));
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        sof = 1'b0;
        pix_valid = 1'b0;
        #1;
        chk("async_rst_window", dut_win(), '0);
        chk("async_rst_valid", win_valid, 1'b0);
        chk("async_rst_en_n", win_en_n, 1'b1);
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        win_cnt = 0;
        for (int r = 0; r < H; r++)
            for (int k = 0; k < W; k++) begin
                px(r == 0 && k == 0, 1'b1, 8'(16 * r + k));
                if (r == 2 && k == 2) begin
                    @(posedge clk); #3;
                    chk("post_rst_first_win", dut_win(), FIRST_WIN);
                end
            end
        idle(1);
        chk("post_rst_count", win_cnt, 4);

        // sof with pix_valid low clears counters mid-frame
        for (int n = 0; n < W + 3; n++) px(n == 0, 1'b1, 8'($urandom));
        px(1'b1, 1'b0, 8'd0);
        win_cnt = 0;
        for (int r = 0; r < H; r++)
            for (int k = 0; k < W; k++) px(1'b0, 1'b1, 8'(16 * r + k));
        idle(1);
        chk("sof_idle_count", win_cnt, 4);

        // two back-to-back frames, second one without sof
        win_cnt = 0;
        fd_cnt = 0;
        for (int fr = 0; fr < 2; fr++)
            for (int r = 0; r < H; r++)
                for (int k = 0; k < W; k++)
                    px(fr == 0 && r == 0 && k == 0, 1'b1, 8'($urandom));
        idle(2);
        chk("b2b_count", win_cnt, 8);
`ifdef WIN_FRAME_DONE_EN
        chk("b2b_frame_done", fd_cnt, 2);
`endif

        // randomized traffic: gaps, mid-frame sof restarts, sof-only pulses
        px(1'b1, 1'b1, 8'($urandom));
        repeat (1500) begin
            int sel;
            sel = $urandom_range(0, 99);
            if (sel < 20)      px(1'b0, 1'b0, 8'($urandom));
            else if (sel < 22) px(1'b1, 1'b0, 8'd0);
            else if (sel < 24) px(1'b1, 1'b1, 8'($urandom));
            else               px(1'b0, 1'b1, 8'($urandom));
        end
        idle(2);
        checking = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
